// File: rtl/memctrl_nport.sv
`default_nettype none
// ============================================================================
//  Module   : memctrl_nport
//  Purpose  : N-port round-robin byte-serial memory controller (loads/stores
//             of 1..DATA_W/8 bytes over an 8-bit RAM with 1-cycle read latency).
//             Optional macro MEMCTRL_IO_STALL_EN: stall stores to the I/O window
//             (addr[17:16]==2'b11) while io_buffer_full is high.
//  Revision : 1.0  initial release
// ============================================================================
module memctrl_nport #(
    parameter int NPORT  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     io_buffer_full,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic [NPORT-1:0]         req,
    input  logic [NPORT-1:0]         we,
    input  logic [3*NPORT-1:0]       len,
    input  logic [ADDR_W*NPORT-1:0]  addr,
    input  logic [DATA_W*NPORT-1:0]  wdata,
    output logic [NPORT-1:0]         done,
    output logic [DATA_W-1:0]        rdata,
    output logic [NPORT-1:0]         grant,
    output logic                     busy
);

    localparam int         PW       = $clog2(NPORT);
    localparam int         NBYTES   = DATA_W / 8;
    localparam logic [2:0] c_MAXLEN = 3'(NBYTES);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    logic [PW-1:0]     r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [NPORT-1:0]  r_grant;

    logic              w_found;
    logic [PW-1:0]     w_pick;
    logic [PW-1:0]     w_idx;
    logic [2:0]        w_len_raw;
    logic [2:0]        w_len_eff;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_stall;

    // Round-robin: scan starting one past the last granted port.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = r_last;
        for (int i = 1; i <= NPORT; i++) begin
            w_idx = PW'((int'(r_last) + i) % NPORT);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_len_raw  = len[3*int'(w_pick) +: 3];
    assign w_len_eff  = (w_len_raw == 3'd0)      ? 3'd1     :
                        (w_len_raw > c_MAXLEN)   ? c_MAXLEN : w_len_raw;
    assign w_cur_addr = r_addr + ADDR_W'(r_cnt);

`ifdef MEMCTRL_IO_STALL_EN
    assign w_stall = (r_state == c_WRITE) && (r_addr[17:16] == 2'b11) && io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io = io_buffer_full;
    assign w_stall     = 1'b0;
`endif

    // RAM-side outputs are decoded from registered state only.
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if ((r_state == c_READ) && (r_cnt < r_len)) begin
            mem_a = w_cur_addr;
        end
        if (r_state == c_WRITE) begin
            mem_a    = w_cur_addr;
            mem_dout = r_wdata[8*int'(r_cnt) +: 8];
            mem_wr   = rdy && !w_stall;
        end
    end

    assign done  = ((r_state == c_DONE) && rdy) ? r_grant : '0;
    assign rdata = r_rdata;
    assign grant = r_grant;
    assign busy  = (r_state != c_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_last  <= PW'(NPORT - 1);
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_grant <= '0;
        end else if (rdy) begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_last  <= w_pick;
                        r_grant <= NPORT'(1) << w_pick;
                        r_addr  <= addr[ADDR_W*int'(w_pick) +: ADDR_W];
                        r_wdata <= wdata[DATA_W*int'(w_pick) +: DATA_W];
                        r_len   <= w_len_eff;
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_state <= we[w_pick] ? c_WRITE : c_READ;
                    end
                end
                c_READ: begin
                    // Data for address cnt-1 arrives one cycle after it was issued.
                    if (r_cnt != 3'd0) begin
                        r_rdata[8*(int'(r_cnt) - 1) +: 8] <= mem_din;
                    end
                    if (r_cnt == r_len) begin
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_WRITE: begin
                    if (!w_stall) begin
                        if (r_cnt == r_len - 3'd1) begin
                            r_state <= c_DONE;
                        end
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_grant <= '0;
                    r_cnt   <= '0;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memctrl_nport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memctrl_nport
//  Purpose  : scoreboard bench for memctrl_nport with a byte-RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memctrl_nport;

    localparam int NPORT = 2;

    logic        clk, rst, rdy, io_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [1:0]  req, we_v, done, grant;
    logic [5:0]  len_v;
    logic [63:0] addr_v, wdata_v;
    logic [31:0] rdata;
    logic        busy;

    logic        p_we    [NPORT];
    logic [2:0]  p_len   [NPORT];
    logic [31:0] p_addr  [NPORT];
    logic [31:0] p_wdata [NPORT];

    assign we_v    = {p_we[1], p_we[0]};
    assign len_v   = {p_len[1], p_len[0]};
    assign addr_v  = {p_addr[1], p_addr[0]};
    assign wdata_v = {p_wdata[1], p_wdata[0]};

    memctrl_nport #(.NPORT(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .req(req), .we(we_v), .len(len_v), .addr(addr_v), .wdata(wdata_v),
        .done(done), .rdata(rdata), .grant(grant), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Untouched RAM bytes follow a fixed pattern: 0x100..0x103 hold 11,22,33,44.
    function automatic bit [7:0] pat(input logic [31:0] a);
        int v;
        v = (int'(a[7:0]) + 1) * 17 + int'(a[15:8]) - 1;
        return 8'(v);
    endfunction

    bit [7:0] ram    [0:65535];
    bit       ram_wr [0:65535];
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) begin
                ram[mem_a[15:0]]    <= mem_dout;
                ram_wr[mem_a[15:0]] <= 1'b1;
            end
            mem_din <= ram_wr[mem_a[15:0]] ? ram[mem_a[15:0]] : pat(mem_a);
        end
    end

    // Reference memory, updated when a store is issued.
    bit [7:0] mdl    [0:65535];
    bit       mdl_wr [0:65535];
    function automatic bit [7:0] mdl_get(input logic [31:0] a);
        return mdl_wr[a[15:0]] ? mdl[a[15:0]] : pat(a);
    endfunction

    typedef struct { int port; logic [31:0] data; int cyc; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    exp_t dq[$];
    wr_t  wq[$];

    int          checks = 0;
    int          errors = 0;
    int          m_last = NPORT - 1;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] mask);
        for (int i = 1; i <= NPORT; i++) begin
            if (mask[(m_last + i) % NPORT]) return (m_last + i) % NPORT;
        end
        return -1;
    endfunction

    // Expected completion of one transfer on port p accepted at cycle c0.
    function automatic int push_expect(input int p, input int c0, input int extra);
        exp_t        e;
        int          l;
        logic [31:0] a;
        l = (p_len[p] == 3'd0) ? 1 : ((p_len[p] > 3'd4) ? 4 : int'(p_len[p]));
        e.port = p;
        e.data = '0;
        for (int i = 0; i < l; i++) begin
            a = p_addr[p] + 32'(i);
            if (p_we[p]) begin
                mdl[a[15:0]]    = p_wdata[p][8*i +: 8];
                mdl_wr[a[15:0]] = 1'b1;
                wq.push_back('{a: a, d: p_wdata[p][8*i +: 8]});
            end else begin
                e.data[8*i +: 8] = mdl_get(a);
            end
        end
        e.cyc = c0 + l + (p_we[p] ? 0 : 1) + extra;
        dq.push_back(e);
        return e.cyc;
    endfunction

    task automatic issue(input logic [1:0] mask, input int extra);
        int p, d;
        p = pick(mask);
        m_last = p;
        d = push_expect(p, cyc + 1, extra);
        req = mask;
        @(posedge clk);
        #1 req = '0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic setp(input int p, input logic w, input logic [2:0] l,
                        input logic [31:0] a, input logic [31:0] d);
        p_we[p] = w; p_len[p] = l; p_addr[p] = a; p_wdata[p] = d;
    endtask

    task automatic monitor();
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_wr) begin
                    if (wq.size() == 0) begin
                        chk("write_unexpected", 64'(mem_wr), 64'd0);
                    end else begin
                        w = wq.pop_front();
                        chk("write_addr", 64'(mem_a), 64'(w.a));
                        chk("write_data", 64'(mem_dout), 64'(w.d));
                    end
                end
                if (done != '0) begin
                    last_rdata = rdata;
                    if (dq.size() == 0) begin
                        chk("done_unexpected", 64'(done), 64'd0);
                    end else begin
                        e = dq.pop_front();
                        chk("done_port", 64'(done), 64'(2'b01 << e.port));
                        chk("done_rdata", 64'(rdata), 64'(e.data));
                        chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        end
    endtask

    task automatic run_all();
        logic [31:0] saved;
        int          n, ex;
        logic [1:0]  mask;
        logic [31:0] wd;

        rst = 1'b1; rdy = 1'b1; io_full = 1'b0; req = '0;
        setp(0, 1'b0, 3'd0, '0, '0);
        setp(1, 1'b0, 3'd0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst_mem_a", 64'(mem_a), 64'd0);
        chk("rst_mem_dout", 64'(mem_dout), 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        m_last = NPORT - 1;
        @(negedge clk);

        // Port 0 load of 4 bytes at 0x100.
        setp(0, 1'b0, 3'd4, 32'h100, '0);
        issue(2'b01, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("load_mem_a", 64'(mem_a), 64'(32'h100 + 32'(i)));
        end
        wait_idle();
        chk("load_rdata_0x100", 64'(last_rdata), 64'h44332211);

        // Port 1 store of 2 bytes, then read back the whole word.
        setp(1, 1'b1, 3'd2, 32'h200, 32'hAABBCCDD);
        issue(2'b10, 0);
        wait_idle();
        setp(1, 1'b0, 3'd4, 32'h200, '0);
        issue(2'b10, 0);
        wait_idle();
        chk("store_readback", 64'(last_rdata), 64'h4534CCDD);

        // Both ports requesting continuously: four back-to-back grants.
        setp(0, 1'b0, 3'd4, 32'h100, '0);
        setp(1, 1'b0, 3'd2, 32'h300, '0);
        ex = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            n = pick(2'b11);
            m_last = n;
            ex = push_expect(n, ex, 0) + 2;
        end
        req = 2'b11;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done != '0) n++;
            if (n == 4) begin
                req = '0;
                break;
            end
        end
        chk("rr_four_done", 64'(n), 64'd4);
        wait_idle();

        // rdy low for three cycles in the middle of a load.
        setp(0, 1'b0, 3'd4, 32'h120, '0);
        issue(2'b01, 3);
        @(negedge clk);
        @(negedge clk);
        #1 rdy = 1'b0;
        saved = mem_a;
        repeat (3) begin
            @(negedge clk);
            chk("freeze_mem_a", 64'(mem_a), 64'(saved));
            chk("freeze_done", 64'(done), 64'd0);
        end
        #1 rdy = 1'b1;
        wait_idle();

        // Single-byte store into the I/O window with the output buffer full.
`ifdef MEMCTRL_IO_STALL_EN
        ex = 4;
`else
        ex = 0;
`endif
        setp(1, 1'b1, 3'd1, 32'h30000, 32'h0000_005A);
        io_full = 1'b1;
        issue(2'b10, ex);
        repeat (4) @(posedge clk);
        #1 io_full = 1'b0;
        wait_idle();

        // Reset while the second byte of a 4-byte store is on the bus.
        wd = $urandom;
        setp(0, 1'b1, 3'd4, 32'h240, wd);
        wq.push_back('{a: 32'h240, d: wd[7:0]});
        wq.push_back('{a: 32'h241, d: wd[15:8]});
        mdl[16'h240]    = wd[7:0];
        mdl_wr[16'h240] = 1'b1;
        m_last = 0;
        req = 2'b01;
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_wr", 64'(mem_wr), 64'd0);
        chk("abort_mem_a", 64'(mem_a), 64'd0);
        chk("abort_mem_dout", 64'(mem_dout), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_grant", 64'(grant), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_last = NPORT - 1;
        setp(0, 1'b0, 3'd2, 32'h240, '0);
        setp(1, 1'b0, 3'd1, 32'h100, '0);
        issue(2'b11, 0);
        wait_idle();

        // Length clamping and address wrap-around.
        setp(1, 1'b0, 3'd0, 32'h100, '0);
        issue(2'b10, 0);
        wait_idle();
        setp(0, 1'b0, 3'd7, 32'hFFFF_FFFE, '0);
        issue(2'b01, 0);
        wait_idle();
        setp(1, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'h1234_5678);
        issue(2'b10, 0);
        wait_idle();

        // Randomised mix of ports, directions, lengths and addresses.
        for (int t = 0; t < 60; t++) begin
            for (int p = 0; p < NPORT; p++) begin
                setp(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                 : 32'h100 + 32'($urandom_range(0, 16'h2FF)),
                     $urandom);
            end
            mask = 2'($urandom_range(1, 3));
            issue(mask, 0);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("done_queue_empty", 64'(dq.size()), 64'd0);
        chk("write_queue_empty", 64'(wq.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; io_full = 1'b0; req = '0;
        fork
            monitor();
            run_all();
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memctrl_nport.md
MEMCTRL_NPORT -- requirements
Module: memctrl_nport

Interface
REQ-001 SHALL have parameters: NPORT, default 2, number of requester ports (2..4); ADDR_W, default 32, address width; DATA_W, default 32, maximum transfer width in bits (multiple of 8, max 32).
REQ-002 SHALL have ports: clk  in  1  system clock, rising edge; rst  in  1  asynchronous, active-high reset; rdy  in  1  global enable, low freezes all state.
REQ-003 SHALL have ports: io_buffer_full  in  1  UART output buffer full; mem_din  in  8  RAM read byte; mem_dout  out  8  RAM write byte; mem_a  out  ADDR_W  RAM byte address; mem_wr  out  1  1=write, 0=read.
REQ-004 SHALL have ports: req  in  NPORT  per-port request; we  in  NPORT  per-port 1=store, 0=load; len  in  3*NPORT  per-port byte count; addr  in  ADDR_W*NPORT  per-port start address; wdata  in  DATA_W*NPORT  per-port store data, little-endian.
REQ-005 SHALL have ports: done  out  NPORT  one-cycle completion pulse per port; rdata  out  DATA_W  load result, valid while any done bit is high; grant  out  NPORT  one-hot port being serviced; busy  out  1  state is not IDLE.

Function
REQ-006 SHALL implement states IDLE, READ, WRITE and DONE, with transitions taken only on rising clk edges where rdy=1.
REQ-007 In IDLE with any req bit set, SHALL grant round-robin: first requesting port after last_grant, modulo NPORT; SHALL latch that port's addr, len, we and wdata; SHALL set cnt=0; SHALL go to WRITE if we=1, else READ.
REQ-008 SHALL treat len=0 as 1 and len>DATA_W/8 as DATA_W/8 (effective length L).
REQ-009 In READ: mem_wr=0 and mem_a=addr+cnt while cnt<L; each edge SHALL capture mem_din into byte cnt-1 of rdata when cnt>=1 and increment cnt; at the edge where cnt==L, SHALL capture the last byte and go to DONE (RAM read latency 1 cycle).
REQ-010 In WRITE: mem_wr=1, mem_a=addr+cnt, mem_dout=byte cnt of wdata; each edge SHALL increment cnt; after the byte with cnt=L-1 is written, SHALL go to DONE.
REQ-011 In DONE: done[granted]=1 for exactly one cycle; rdata bytes at index >=L SHALL be zero (loads), and rdata SHALL be 0 for stores; the next state is always IDLE.
REQ-012 Requesters SHALL drop req in the done cycle; req still high in the following IDLE cycle is a new request.
REQ-013 Outside READ and WRITE: mem_wr=0, mem_a=0, mem_dout=0.
REQ-014 mem_a, mem_dout and mem_wr SHALL depend only on registered state, never combinationally on req.
REQ-015 Latency SHALL be: load of L bytes accepted at edge E0 gives done in cycle E0+L+1; store gives done in cycle E0+L.
REQ-016 When rdy=0: no state, counter, or pointer change; mem_wr forced 0; done held 0.
REQ-017 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-018 On rst (asynchronous): state=IDLE, cnt=0, last_grant=NPORT-1 so port 0 wins first; mem_a, mem_dout, mem_wr, done, rdata, grant, busy all 0.
REQ-019 rst mid-transfer SHALL abort with no done pulse, and no further mem_wr SHALL be issued.

Configuration
REQ-020 With macro MEMCTRL_IO_STALL_EN defined: in WRITE to an address with addr[17:16]==2'b11, while io_buffer_full=1, SHALL hold cnt and state with mem_wr=0, and resume when io_buffer_full=0.
REQ-021 Without MEMCTRL_IO_STALL_EN: io_buffer_full SHALL be ignored; the port remains present.

Verification
REQ-022 Reset, then port0 load L=4 at 0x100 with RAM bytes 11,22,33,44: mem_a 0x100..0x103 in consecutive cycles; done[0] at E0+5; rdata=0x44332211.
REQ-023 Port1 store L=2 at 0x200, wdata=0xAABBCCDD: writes DD@0x200, CC@0x201; done[1] at E0+2; RAM bytes 0x202/0x203 unchanged.
REQ-024 req=2'b11 held continuously, NPORT=2: grants alternate 0,1,0,1 with one IDLE cycle between transfers.
REQ-025 rdy low for 3 cycles mid-load: mem_a frozen, no done; after rdy returns, result is identical to the unstalled run.
REQ-026 MEMCTRL_IO_STALL_EN defined, store L=1 to 0x30000 with io_buffer_full high for 4 cycles: mem_wr=0 for those cycles, then one write, then done; with macro undefined, write is immediate.
REQ-027 rst asserted during WRITE cnt=1 of L=4: outputs 0 immediately; no done; the next request is granted to port 0.
